// File: rtl/cdb_result_queue.sv
// Per-unit result FIFO between a functional unit's writeback port and the CDB arbiter.
// Optional combinational empty-queue bypass: define CDB_RESULT_QUEUE_BYPASS_EN.
module cdb_result_queue #(
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_TAG            = 6,
    parameter int DEPTH             = 4,
    parameter int BW_STALL          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic [BW_TAG-1:0]            i_tag,
    input  logic [BW_PROCESSOR_DATA-1:0] i_wdata,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [BW_TAG-1:0]            o_tag,
    output logic [BW_PROCESSOR_DATA-1:0] o_wdata,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic [BW_STALL-1:0]          o_stall_cycles
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = BW_TAG + BW_PROCESSOR_DATA;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]       mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [BW_STALL-1:0] stall_cnt;

    logic empty;
    logic bypass;
    logic q_pop;
    logic push;
    logic bypass_pop;

    // Handshake: a transfer happens on a rising edge where valid && ready on
    // the same side. i_ready depends only on occupancy, never on o_ready, and
    // an offered head (o_valid=1) holds tag/data until it is popped or flushed.
    assign empty   = (count == '0);
    assign i_ready = (count != FULL);

`ifdef CDB_RESULT_QUEUE_BYPASS_EN
    assign bypass = empty && i_valid && !i_flush;
`else
    assign bypass = 1'b0;
`endif

    assign o_valid    = !empty || bypass;
    assign q_pop      = !empty && o_ready;
    assign bypass_pop = bypass && o_ready;
    // A bypassed result granted in the same cycle leaves without being stored.
    assign push       = i_valid && i_ready && !bypass_pop;

    always_comb begin
        o_tag   = '0;
        o_wdata = '0;
        if (!empty) begin
            {o_tag, o_wdata} = mem[rd_ptr];
        end else if (bypass) begin
            o_tag   = i_tag;
            o_wdata = i_wdata;
        end
    end

    assign o_count        = count;
    assign o_stall_cycles = stall_cnt;

    always_ff @(posedge clk) begin
        if (push && !i_flush) begin
            mem[wr_ptr] <= {i_tag, i_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, q_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Counts wait cycles of a stored head only; it is already zero whenever the queue empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (i_flush || q_pop || bypass_pop) begin
            stall_cnt <= '0;
        end else if (!empty && !o_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + BW_STALL'(1);
        end
    end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Directed bench for cdb_result_queue: ordering, wrap, stall saturation, flush, async reset
// and, when CDB_RESULT_QUEUE_BYPASS_EN is defined, the empty-queue bypass.
module tb_cdb_result_queue;

    localparam int BW_PROCESSOR_DATA = 32;
    localparam int BW_TAG            = 6;
    localparam int DEPTH             = 4;
    localparam int BW_STALL          = 8;
    localparam int EW                = BW_TAG + BW_PROCESSOR_DATA;

    logic                         clk;
    logic                         rst;
    logic                         i_flush;
    logic                         i_valid;
    logic                         i_ready;
    logic [BW_TAG-1:0]            i_tag;
    logic [BW_PROCESSOR_DATA-1:0] i_wdata;
    logic                         o_valid;
    logic                         o_ready;
    logic [BW_TAG-1:0]            o_tag;
    logic [BW_PROCESSOR_DATA-1:0] o_wdata;
    logic [$clog2(DEPTH):0]       o_count;
    logic [BW_STALL-1:0]          o_stall_cycles;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    cdb_result_queue #(
        .BW_PROCESSOR_DATA(BW_PROCESSOR_DATA),
        .BW_TAG           (BW_TAG),
        .DEPTH            (DEPTH),
        .BW_STALL         (BW_STALL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_tag         (i_tag),
        .i_wdata       (i_wdata),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_tag         (o_tag),
        .o_wdata       (o_wdata),
        .o_count       (o_count),
        .o_stall_cycles(o_stall_cycles)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_head(input string name);
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check(name, 64'({o_tag, o_wdata}), 64'(e));
    endtask

    // driver: present one result for a single edge with o_ready low
    task automatic push_one(input logic [BW_TAG-1:0] tag, input logic [BW_PROCESSOR_DATA-1:0] data);
        i_valid = 1'b1;
        i_tag   = tag;
        i_wdata = data;
        exp_q.push_back({tag, data});
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        i_tag = '0; i_wdata = '0;

        #3;
        check("reset_o_valid", 64'(o_valid), 64'd0);
        check("reset_o_count", 64'(o_count), 64'd0);
        check("reset_stall",   64'(o_stall_cycles), 64'd0);
        check("reset_o_tag",   64'(o_tag), 64'd0);
        check("reset_o_wdata", 64'(o_wdata), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_reset_i_ready", 64'(i_ready), 64'd1);

        // four back-to-back pushes into a stalled arbiter
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_tag   = BW_TAG'(i + 1);
            i_wdata = BW_PROCESSOR_DATA'(32'h10 + i);
            #1;
            check("fill_i_ready", 64'(i_ready), 64'd1);
`ifndef CDB_RESULT_QUEUE_BYPASS_EN
            if (i == 0) check("fill_latency_o_valid", 64'(o_valid), 64'd0);
`endif
            exp_q.push_back({i_tag, i_wdata});
            tick();
        end
        i_valid = 1'b0;
        #1;
        check("full_count",   64'(o_count), 64'd4);
        check("full_i_ready", 64'(i_ready), 64'd0);
        check("full_o_valid", 64'(o_valid), 64'd1);
        check("full_stall",   64'(o_stall_cycles), 64'd3);

        // pop while full with a pending input: the input must be refused
        i_valid = 1'b1; i_tag = 6'd15; i_wdata = 32'hFF; o_ready = 1'b1;
        #1;
        check("full_pop_i_ready", 64'(i_ready), 64'd0);
        check_head("drain_head_1");
        tick();
        i_valid = 1'b0;
        #1;
        check("full_pop_count", 64'(o_count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check_head("drain_head");
            tick();
        end
        o_ready = 1'b0;
        #1;
        check("drained_count",   64'(o_count), 64'd0);
        check("drained_o_valid", 64'(o_valid), 64'd0);
        check("drained_o_tag",   64'(o_tag), 64'd0);
        check("drained_o_wdata", 64'(o_wdata), 64'd0);

        // steady push+pop with two entries, wrapping the pointers
        push_one(6'h21, 32'h200);
        push_one(6'h22, 32'h201);
        for (int i = 0; i < 6; i++) begin
            i_valid = 1'b1; i_tag = 6'd7; i_wdata = 32'h700 + i; o_ready = 1'b1;
            #1;
            check_head("stream_head");
            check("stream_count", 64'(o_count), 64'd2);
            exp_q.push_back({i_tag, i_wdata});
            tick();
        end
        i_valid = 1'b0;
        #1;
        check("stream_end_count", 64'(o_count), 64'd2);
        check_head("stream_tail_1");
        tick();
        check_head("stream_tail_2");
        tick();
        o_ready = 1'b0;
        #1;
        check("stream_empty", 64'(o_valid), 64'd0);

        // long stall on head tag 5 saturates the counter
        push_one(6'd5, 32'h55);
        repeat (10) tick();
        check("stall_10", 64'(o_stall_cycles), 64'd10);
        repeat (290) tick();
        check("stall_sat",      64'(o_stall_cycles), 64'd255);
        check("stall_hold_tag", 64'({o_tag, o_wdata}), 64'({6'd5, 32'h55}));
        o_ready = 1'b1;
        #1;
        check_head("stall_pop_head");
        tick();
        o_ready = 1'b0;
        #1;
        check("stall_cleared", 64'(o_stall_cycles), 64'd0);
        check("stall_popped",  64'(o_valid), 64'd0);

        // flush with three entries and a concurrent input
        push_one(6'hA, 32'hA0);
        push_one(6'hB, 32'hB0);
        push_one(6'hC, 32'hC0);
        exp_q.delete();
        i_valid = 1'b1; i_tag = 6'd9; i_wdata = 32'h99; i_flush = 1'b1;
        #1;
        check("flush_i_ready", 64'(i_ready), 64'd1);
        tick();
        i_valid = 1'b0; i_flush = 1'b0;
        #1;
        check("flush_count",   64'(o_count), 64'd0);
        check("flush_o_valid", 64'(o_valid), 64'd0);
        check("flush_stall",   64'(o_stall_cycles), 64'd0);
        tick();
        check("flush_no_tag9", 64'(o_valid), 64'd0);

        // asynchronous reset mid-cycle
        push_one(6'h11, 32'h1);
        push_one(6'h12, 32'h2);
        push_one(6'h13, 32'h3);
        exp_q.delete();
        #1;
        check("pre_rst_count", 64'(o_count), 64'd3);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_o_valid", 64'(o_valid), 64'd0);
        check("async_rst_count",   64'(o_count), 64'd0);
        #2;
        rst = 1'b0;
        tick();
        i_valid = 1'b1; i_tag = 6'd2; i_wdata = 32'h222;
        exp_q.push_back({i_tag, i_wdata});
`ifndef CDB_RESULT_QUEUE_BYPASS_EN
        #1;
        check("rst_push_latency", 64'(o_valid), 64'd0);
`endif
        tick();
        i_valid = 1'b0;
        #1;
        check("rst_push_o_valid", 64'(o_valid), 64'd1);
        check("rst_push_count",   64'(o_count), 64'd1);
        check_head("rst_push_head");
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        #1;
        check("rst_push_popped", 64'(o_valid), 64'd0);

`ifdef CDB_RESULT_QUEUE_BYPASS_EN
        // zero-latency bypass, granted and not granted
        i_valid = 1'b1; i_tag = 6'd3; i_wdata = 32'hAB; o_ready = 1'b1;
        #1;
        check("bypass_o_valid", 64'(o_valid), 64'd1);
        check("bypass_o_tag",   64'(o_tag), 64'd3);
        check("bypass_o_wdata", 64'(o_wdata), 64'hAB);
        tick();
        i_valid = 1'b0; o_ready = 1'b0;
        #1;
        check("bypass_count", 64'(o_count), 64'd0);
        i_valid = 1'b1; i_flush = 1'b1;
        #1;
        check("bypass_flush_o_valid", 64'(o_valid), 64'd0);
        i_flush = 1'b0;
        #1;
        check("bypass_nogrant_o_valid", 64'(o_valid), 64'd1);
        tick();
        i_valid = 1'b0;
        #1;
        check("bypass_nogrant_count", 64'(o_count), 64'd1);
        check("bypass_nogrant_tag",   64'(o_tag), 64'd3);
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_result_queue.md
Name: cdb_result_queue

Overview:
- Per-functional-unit result buffer between a unit's writeback port (integer, multiplier, branch or load) and the common data bus arbiter input.
- The arbiter grants one source per cycle by fixed priority, so lower-priority units can lose arbitration. This queue absorbs their results so the unit pipeline does not stall.
- Presents in-order tag/data pairs to the arbiter with a valid/ready handshake and reports head-of-queue stall cycles for performance analysis.

Parameters:
- BW_PROCESSOR_DATA, 32, width of result data.
- BW_TAG, 6, width of the reservation-station tag.
- DEPTH, 4, number of entries; power of two, at least 2.
- BW_STALL, 8, width of the saturating stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_flush  input  1  synchronous flush on branch mispredict; empties the queue.
- i_valid  input  1  result from the functional unit is valid.
- i_ready  output  1  the queue can accept a result.
- i_tag  input  BW_TAG  tag of the incoming result.
- i_wdata  input  BW_PROCESSOR_DATA  incoming result data.
- o_valid  output  1  the head entry is valid and offered to the arbiter.
- o_ready  input  1  the arbiter grants this source.
- o_tag  output  BW_TAG  tag of the head entry.
- o_wdata  output  BW_PROCESSOR_DATA  data of the head entry.
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_stall_cycles  output  BW_STALL  cycles the current head has waited with o_valid=1 and o_ready=0.

Behaviour:
- Reset (rst=1, asynchronous):
  - wr_ptr=rd_ptr=0, count=0, stall counter=0.
  - Outputs: o_valid=0, o_count=0, o_stall_cycles=0, i_ready=1 (after reset is released), o_tag=0, o_wdata=0.
  - Entry storage is not reset, but o_tag/o_wdata must read as 0 while empty.
- Storage:
  - Circular buffer indexed by wr_ptr/rd_ptr, each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
  - Count is held in a separate register.
- Push:
  - Occurs when i_valid && i_ready.
  - Writes {i_tag,i_wdata} at wr_ptr; wr_ptr++.
- Pop:
  - Occurs when o_valid && o_ready; rd_ptr++.
- i_ready = (count < DEPTH).
  - A push into a full queue is not accepted in the same cycle as a pop; this keeps o_ready off any combinational path to i_ready.
- o_valid = (count != 0). o_tag/o_wdata come combinationally from the head entry.
- Latency: a result pushed in cycle N is first visible at the output in cycle N+1 (without the optional feature).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Handshake rules:
  - While o_valid=1 and o_ready=0, o_tag/o_wdata must be held stable.
  - o_valid never drops without a pop or a flush.
- Flush (i_flush=1 at the clock edge):
  - Sets count=0, rd_ptr=wr_ptr=0, stall counter=0.
  - Any push or pop in that cycle is discarded.
  - i_ready stays per the count rule during the flush cycle, but the accepted input is dropped.
  - Flush has priority over everything except rst.
- Stall counter:
  - Increments when o_valid && !o_ready, saturating at 2^BW_STALL-1.
  - Clears to 0 on any pop or flush.
  - Holds its value while the queue is empty.
- Order: strictly FIFO; tags are never reordered or duplicated.
- Reset asserted mid-operation discards all entries immediately. o_valid falls asynchronously.

Optional Feature:
- Macro: CDB_RESULT_QUEUE_BYPASS_EN.
- With the macro defined, when count==0 and i_valid=1:
  - The input passes combinationally to the output: o_valid=1, o_tag=i_tag, o_wdata=i_wdata.
  - If o_ready=1 in that cycle, the result leaves with zero latency and nothing is written. Otherwise it is written into the queue normally.
  - Flush suppresses the bypass: o_valid=0 while i_flush=1 and the queue is empty.
- Without the macro, there is no combinational i→o path and latency is always 1 cycle.

Test Plan:
- Four back-to-back pushes with tags 1,2,3,4 and data 0x10..0x13, o_ready=0 → o_count=4, i_ready=0; then o_ready=1 for 4 cycles → outputs tags 1,2,3,4 in order, o_count returns to 0, o_valid=0.
- Queue holding 2 entries, simultaneous push (tag 7) and pop for 6 cycles → o_count stays 2; tag order is preserved across the pointer wrap.
- Head tag 5 held with o_ready=0 for 300 cycles, BW_STALL=8 → o_stall_cycles saturates at 255 with o_tag/o_wdata stable; o_ready=1 → pop, counter reads 0 on the next cycle.
- Three entries plus i_valid=1 (tag 9) with i_flush=1 → next cycle o_count=0, o_valid=0; tag 9 never appears on the output.
- rst pulse asserted mid-cycle while the queue holds 3 entries → o_valid=0 and o_count=0 immediately (asynchronous); after release, the first push (tag 2) appears at the output one cycle later.
- With CDB_RESULT_QUEUE_BYPASS_EN, empty queue, i_valid=1 tag 3 data 0xAB, o_ready=1 → o_valid=1 and o_tag=3 in the same cycle; o_count stays 0. Repeat with o_ready=0 → o_count=1 next cycle.
